// File: rtl/uart_packet_ctrl.sv
// Packet engine between the CPU side and the UART transceiver byte FIFOs.
// Packet format on the wire: [channel, length, payload LSB-first, checksum],
// where checksum = XOR of channel, length and all payload bytes.
//
// TX states
//   T_IDLE | waiting for a request, tx_ready high
//   T_CHAN | emitting channel byte
//   T_LEN  | emitting (clamped) length byte
//   T_DATA | emitting payload byte tx_idx
//   T_SUM  | emitting checksum byte
// RX states
//   R_IDLE | next byte is a channel
//   R_LEN  | next byte is the length
//   R_DATA | next byte is payload byte rx_idx
//   R_SUM  | next byte is the checksum
//   R_WAIT | one-cycle gap after every pop, then go to rx_ret
module uart_packet_ctrl #(
  parameter int MAX_LEN = 4,
  parameter int TIMEOUT = 100000
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  output logic                 send_flag,
  output logic [7:0]           send_data,
  input  logic                 sendable,
  output logic                 recv_flag,
  input  logic [7:0]           recv_data,
  input  logic                 receivable,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [7:0]           tx_channel,
  input  logic [3:0]           tx_length,
  input  logic [8*MAX_LEN-1:0] tx_data,
  output logic                 rx_valid,
  output logic                 rx_err,
  output logic [7:0]           rx_channel,
  output logic [3:0]           rx_length,
  output logic [8*MAX_LEN-1:0] rx_data
);

  localparam int DW = 8 * MAX_LEN;
  localparam int CW = (TIMEOUT > 4) ? $clog2(TIMEOUT) : 2;
  localparam logic [3:0]    MAX_LEN_L = 4'(MAX_LEN);
  // Timeout fires on the edge where the counter would reach TIMEOUT-1.
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 2);

  typedef enum logic [2:0] {T_IDLE, T_CHAN, T_LEN, T_DATA, T_SUM} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_LEN, R_DATA, R_SUM, R_WAIT} rx_state_t;

  tx_state_t         tx_state_q, tx_state_d;
  logic [7:0]        tx_chan_q, tx_chan_d;
  logic [3:0]        tx_len_q, tx_len_d;
  logic [DW-1:0]     tx_data_q, tx_data_d;
  logic [3:0]        tx_idx_q, tx_idx_d;
  logic [7:0]        tx_sum_q, tx_sum_d;
  logic [7:0]        tx_byte;

  rx_state_t         rx_state_q, rx_state_d;
  rx_state_t         rx_ret_q, rx_ret_d;
  logic              rx_en_q;
  logic [7:0]        rx_chan_w_q, rx_chan_w_d;
  logic [3:0]        rx_len_w_q, rx_len_w_d;
  logic [DW-1:0]     rx_buf_q, rx_buf_d;
  logic [3:0]        rx_idx_q, rx_idx_d;
  logic [7:0]        rx_sum_q, rx_sum_d;
  logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_err_q, rx_err_d;
  logic [7:0]        rx_channel_q, rx_channel_d;
  logic [3:0]        rx_length_q, rx_length_d;
  logic [DW-1:0]     rx_data_q, rx_data_d;
  logic              rx_pop;

  // TX state register and datapath flops
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tx_state_q <= T_IDLE;
      tx_chan_q  <= '0;
      tx_len_q   <= '0;
      tx_data_q  <= '0;
      tx_idx_q   <= '0;
      tx_sum_q   <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_chan_q  <= tx_chan_d;
      tx_len_q   <= tx_len_d;
      tx_data_q  <= tx_data_d;
      tx_idx_q   <= tx_idx_d;
      tx_sum_q   <= tx_sum_d;
    end
  end

  assign tx_byte = 8'(tx_data_q >> {tx_idx_q, 3'b000});

  // TX next state: one byte per sendable cycle, checksum accumulated as bytes leave
  always_comb begin
    tx_state_d = tx_state_q;
    tx_chan_d  = tx_chan_q;
    tx_len_d   = tx_len_q;
    tx_data_d  = tx_data_q;
    tx_idx_d   = tx_idx_q;
    tx_sum_d   = tx_sum_q;
    case (tx_state_q)
      T_IDLE: if (tx_valid) begin
        tx_chan_d  = tx_channel;
        tx_len_d   = (tx_length > MAX_LEN_L) ? MAX_LEN_L : tx_length;
        tx_data_d  = tx_data;
        tx_idx_d   = '0;
        tx_sum_d   = '0;
        tx_state_d = T_CHAN;
      end
      T_CHAN: if (sendable) begin
        tx_sum_d   = tx_sum_q ^ tx_chan_q;
        tx_state_d = T_LEN;
      end
      T_LEN: if (sendable) begin
        tx_sum_d   = tx_sum_q ^ {4'b0000, tx_len_q};
        tx_idx_d   = '0;
        tx_state_d = (tx_len_q == 4'd0) ? T_SUM : T_DATA;
      end
      T_DATA: if (sendable) begin
        tx_sum_d = tx_sum_q ^ tx_byte;
        tx_idx_d = tx_idx_q + 4'd1;
        if (tx_idx_q + 4'd1 == tx_len_q) tx_state_d = T_SUM;
      end
      T_SUM: if (sendable) tx_state_d = T_IDLE;
      default: tx_state_d = T_IDLE;
    endcase
  end

  // TX outputs: push only when the send FIFO has room
  always_comb begin
    tx_ready  = (tx_state_q == T_IDLE);
    send_flag = (tx_state_q != T_IDLE) && sendable;
    case (tx_state_q)
      T_CHAN:  send_data = tx_chan_q;
      T_LEN:   send_data = {4'b0000, tx_len_q};
      T_DATA:  send_data = tx_byte;
      T_SUM:   send_data = tx_sum_q;
      default: send_data = 8'h00;
    endcase
  end

  // RX state register, working buffer, timeout counter and result registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_state_q   <= R_IDLE;
      rx_ret_q     <= R_IDLE;
      rx_en_q      <= 1'b0;
      rx_chan_w_q  <= '0;
      rx_len_w_q   <= '0;
      rx_buf_q     <= '0;
      rx_idx_q     <= '0;
      rx_sum_q     <= '0;
      rx_cnt_q     <= '0;
      rx_valid_q   <= 1'b0;
      rx_err_q     <= 1'b0;
      rx_channel_q <= '0;
      rx_length_q  <= '0;
      rx_data_q    <= '0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_ret_q     <= rx_ret_d;
      rx_en_q      <= 1'b1;
      rx_chan_w_q  <= rx_chan_w_d;
      rx_len_w_q   <= rx_len_w_d;
      rx_buf_q     <= rx_buf_d;
      rx_idx_q     <= rx_idx_d;
      rx_sum_q     <= rx_sum_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_valid_q   <= rx_valid_d;
      rx_err_q     <= rx_err_d;
      rx_channel_q <= rx_channel_d;
      rx_length_q  <= rx_length_d;
      rx_data_q    <= rx_data_d;
    end
  end

  // RX next state: parse one byte per pop, publish result on the following cycle
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_ret_d     = rx_ret_q;
    rx_chan_w_d  = rx_chan_w_q;
    rx_len_w_d   = rx_len_w_q;
    rx_buf_d     = rx_buf_q;
    rx_idx_d     = rx_idx_q;
    rx_sum_d     = rx_sum_q;
    rx_valid_d   = 1'b0;
    rx_err_d     = 1'b0;
    rx_channel_d = rx_channel_q;
    rx_length_d  = rx_length_q;
    rx_data_d    = rx_data_q;
    rx_cnt_d     = (rx_state_q == R_IDLE || rx_pop) ? '0 : rx_cnt_q + CW'(1);
    case (rx_state_q)
      R_IDLE: if (rx_pop) begin
        rx_chan_w_d = recv_data;
        rx_len_w_d  = '0;
        rx_buf_d    = '0;
        rx_idx_d    = '0;
        rx_sum_d    = recv_data;
        rx_ret_d    = R_LEN;
        rx_state_d  = R_WAIT;
      end
      R_LEN: if (rx_pop) begin
        rx_len_w_d = recv_data[3:0];
        rx_sum_d   = rx_sum_q ^ recv_data;
        rx_state_d = R_WAIT;
        if (recv_data > 8'(MAX_LEN)) begin
          // Oversized length: report and resync on the next byte as a channel
          rx_valid_d   = 1'b1;
          rx_err_d     = 1'b1;
          rx_channel_d = rx_chan_w_q;
          rx_length_d  = recv_data[3:0];
          rx_data_d    = '0;
          rx_ret_d     = R_IDLE;
        end else begin
          rx_ret_d = (recv_data == 8'h00) ? R_SUM : R_DATA;
        end
      end
      R_DATA: if (rx_pop) begin
        rx_buf_d   = rx_buf_q | (DW'(recv_data) << {rx_idx_q, 3'b000});
        rx_sum_d   = rx_sum_q ^ recv_data;
        rx_idx_d   = rx_idx_q + 4'd1;
        rx_ret_d   = (rx_idx_q + 4'd1 == rx_len_w_q) ? R_SUM : R_DATA;
        rx_state_d = R_WAIT;
      end
      R_SUM: if (rx_pop) begin
        rx_valid_d   = 1'b1;
        rx_err_d     = (recv_data != rx_sum_q);
        rx_channel_d = rx_chan_w_q;
        rx_length_d  = rx_len_w_q;
        rx_data_d    = rx_buf_q;
        rx_ret_d     = R_IDLE;
        rx_state_d   = R_WAIT;
      end
      R_WAIT:  rx_state_d = rx_ret_q;
      default: rx_state_d = R_IDLE;
    endcase
    // Inter-byte timeout publishes whatever was collected so far
    if (rx_state_q != R_IDLE && !rx_pop && rx_cnt_q == TO_LAST) begin
      rx_valid_d   = 1'b1;
      rx_err_d     = 1'b1;
      rx_channel_d = rx_chan_w_q;
      rx_length_d  = rx_len_w_q;
      rx_data_d    = rx_buf_q;
      rx_cnt_d     = '0;
      rx_state_d   = R_IDLE;
    end
  end

  // RX outputs: pop whenever data is present outside the post-pop gap
  always_comb begin
    rx_pop     = rx_en_q && receivable && (rx_state_q != R_WAIT);
    recv_flag  = rx_pop;
    rx_valid   = rx_valid_q;
    rx_err     = rx_err_q;
    rx_channel = rx_channel_q;
    rx_length  = rx_length_q;
    rx_data    = rx_data_q;
  end

endmodule

// File: tb/tb_uart_packet_ctrl.sv
// Scoreboard bench for uart_packet_ctrl: stimulus tasks push expected bytes /
// results into queues, a negedge monitor pops and compares them.
module tb_uart_packet_ctrl;

  localparam int MAX_LEN = 4;
  localparam int TIMEOUT = 16;
  localparam int DW      = 8 * MAX_LEN;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          send_flag, sendable;
  logic [7:0]    send_data;
  logic          recv_flag, receivable;
  logic [7:0]    recv_data;
  logic          tx_valid, tx_ready;
  logic [7:0]    tx_channel;
  logic [3:0]    tx_length;
  logic [DW-1:0] tx_data;
  logic          rx_valid, rx_err;
  logic [7:0]    rx_channel;
  logic [3:0]    rx_length;
  logic [DW-1:0] rx_data;

  uart_packet_ctrl #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .send_flag(send_flag), .send_data(send_data), .sendable(sendable),
    .recv_flag(recv_flag), .recv_data(recv_data), .receivable(receivable),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_channel(tx_channel),
    .tx_length(tx_length), .tx_data(tx_data),
    .rx_valid(rx_valid), .rx_err(rx_err), .rx_channel(rx_channel),
    .rx_length(rx_length), .rx_data(rx_data)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic          err;
    bit            fields;
    int            gap;
    logic [7:0]    chan;
    logic [3:0]    len;
    logic [DW-1:0] data;
  } rx_exp_t;

  logic [7:0] tx_exp[$];
  rx_exp_t    rx_exp[$];
  logic [7:0] rx_fifo[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_pop = 0;
  int first_pop = -1;
  int tx_seen  = 0;
  bit stall_arm = 0;
  int stall_cnt = 0;
  int tx_stall_pct = 0;
  int rx_gap_pct = 0;
  bit loopback = 0;
  bit prev_recv = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Receive FIFO model: first-word fall-through, popped on recv_flag
  initial begin
    bit pop;
    receivable = 1'b0;
    recv_data  = 8'h00;
    forever begin
      @(negedge CLK);
      pop = recv_flag && receivable;
      @(posedge CLK);
      #1;
      if (pop && rx_fifo.size() > 0) void'(rx_fifo.pop_front());
      receivable = (int'($urandom_range(99)) >= rx_gap_pct) && (rx_fifo.size() > 0);
      recv_data  = (rx_fifo.size() > 0) ? rx_fifo[0] : 8'h00;
    end
  end

  // Send FIFO space model
  initial begin
    sendable = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      if (stall_cnt > 0) begin
        sendable = 1'b0;
        stall_cnt--;
      end else begin
        sendable = (int'($urandom_range(99)) >= tx_stall_pct);
      end
    end
  end

  // Monitor: compare every DUT push and every rx result against the scoreboard
  initial forever begin
    rx_exp_t e;
    @(negedge CLK);
    if (rx_valid) begin
      if (rx_exp.size() == 0) fail_now("unexpected rx_valid");
      else begin
        e = rx_exp.pop_front();
        chk("rx_err", rx_err, e.err);
        chk("rx_valid latency after last pop", cyc - last_pop, e.gap);
        if (e.fields) begin
          chk("rx_channel", rx_channel, e.chan);
          chk("rx_length", rx_length, e.len);
          chk("rx_data", rx_data, e.data);
        end
      end
    end
    if (!sendable) chk("send_flag while not sendable", send_flag, 1'b0);
    if (send_flag) begin
      if (tx_exp.size() == 0) fail_now("unexpected send_flag");
      else chk("send_data", send_data, tx_exp.pop_front());
      if (loopback) rx_fifo.push_back(send_data);
      tx_seen++;
      if (stall_arm && tx_seen == 2) begin
        stall_cnt = 3;
        stall_arm = 0;
      end
    end
    if (recv_flag) begin
      chk("recv_flag back-to-back", prev_recv, 1'b0);
      last_pop = cyc;
      if (first_pop < 0) first_pop = cyc;
    end
    prev_recv = recv_flag;
  end

  // Issue one TX request; expected wire bytes come from the packet rules
  task automatic send_pkt(input logic [7:0] ch, input logic [3:0] ln, input logic [DW-1:0] d);
    int n;
    int w = 0;
    logic [7:0] s;
    n = (int'(ln) > MAX_LEN) ? MAX_LEN : int'(ln);
    @(negedge CLK);
    while (!tx_ready && w < 200) begin
      @(negedge CLK);
      w++;
    end
    if (!tx_ready) fail_now("tx_ready wait expired");
    s = ch ^ 8'(n);
    tx_exp.push_back(ch);
    tx_exp.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      tx_exp.push_back(d[8*i +: 8]);
      s ^= d[8*i +: 8];
    end
    tx_exp.push_back(s);
    tx_valid = 1'b1;
    tx_channel = ch;
    tx_length = ln;
    tx_data = d;
    @(posedge CLK);
    #1;
    tx_valid = 1'b0;
    tx_channel = 8'($urandom);
    tx_length = 4'($urandom);
    tx_data = DW'($urandom);
  endtask

  // Queue an RX packet (optionally only its expectation); sum_ovr < 0 = correct checksum
  task automatic rx_pkt(input logic [7:0] ch, input logic [7:0] ln, input logic [DW-1:0] d,
                        input int sum_ovr, input bit push_bytes);
    rx_exp_t e;
    logic [7:0] s;
    logic [7:0] sb;
    if (push_bytes) begin
      rx_fifo.push_back(ch);
      rx_fifo.push_back(ln);
    end
    e.chan = ch;
    e.len  = ln[3:0];
    e.data = '0;
    e.gap  = 1;
    if (int'(ln) > MAX_LEN) begin
      e.err = 1'b1;
      e.fields = 0;
      rx_exp.push_back(e);
      return;
    end
    s = ch ^ ln;
    for (int i = 0; i < int'(ln); i++) begin
      if (push_bytes) rx_fifo.push_back(d[8*i +: 8]);
      e.data[8*i +: 8] = d[8*i +: 8];
      s ^= d[8*i +: 8];
    end
    sb = (sum_ovr < 0) ? s : 8'(sum_ovr);
    if (push_bytes) rx_fifo.push_back(sb);
    e.err = (sb != s);
    e.fields = 1;
    rx_exp.push_back(e);
  endtask

  task automatic drain(input int maxc);
    int k = 0;
    while ((tx_exp.size() > 0 || rx_exp.size() > 0 || rx_fifo.size() > 0) && k < maxc) begin
      @(negedge CLK);
      k++;
    end
    if (k >= maxc) fail_now("drain budget expired");
    repeat (TIMEOUT + 4) @(negedge CLK);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rx_exp_t e;
    tx_valid = 1'b0;
    tx_channel = '0;
    tx_length = '0;
    tx_data = '0;
    #1;
    chk("reset tx_ready", tx_ready, 1'b1);
    chk("reset send_flag", send_flag, 1'b0);
    chk("reset recv_flag", recv_flag, 1'b0);
    chk("reset rx_valid", rx_valid, 1'b0);
    chk("reset rx_err", rx_err, 1'b0);
    chk("reset rx_channel", rx_channel, 8'h00);
    chk("reset rx_length", rx_length, 4'h0);
    chk("reset rx_data", rx_data, '0);
    repeat (3) @(posedge CLK);
    #2 RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    // Back-to-back TX bytes with the send FIFO always open
    send_pkt(8'h01, 4'd2, 32'h0000_3412);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("tx burst send_flag", send_flag, 1'b1);
      chk("tx burst tx_ready low", tx_ready, 1'b0);
    end
    @(negedge CLK);
    chk("tx_ready after checksum", tx_ready, 1'b1);

    // Three-cycle stall after the length byte
    tx_seen = 0;
    stall_arm = 1;
    send_pkt(8'h01, 4'd2, 32'h0000_3412);
    @(negedge CLK);
    k = 0;
    while (!tx_ready && k < 50) begin
      k++;
      @(negedge CLK);
    end
    chk("stalled packet busy cycles", k, 8);
    drain(100);

    // Directed RX: good packet, bad checksum, zero-length, bad length, resync
    first_pop = -1;
    rx_pkt(8'h01, 8'h02, 32'h0000_3412, -1, 1);
    drain(100);
    chk("rx pop spacing", last_pop - first_pop, 8);
    rx_pkt(8'h01, 8'h02, 32'h0000_3412, 8'h26, 1);
    rx_pkt(8'h07, 8'h00, 32'h0, -1, 1);
    rx_pkt(8'h05, 8'h09, 32'h0, -1, 1);
    rx_pkt(8'h33, 8'h04, 32'hdead_beef, -1, 1);
    drain(200);

    // Timeout after 01,02 then starvation
    rx_fifo.push_back(8'h01);
    rx_fifo.push_back(8'h02);
    e.err = 1'b1; e.fields = 1; e.gap = TIMEOUT;
    e.chan = 8'h01; e.len = 4'd2; e.data = '0;
    rx_exp.push_back(e);
    drain(200);

    // Randomized concurrent TX and RX traffic with backpressure and gaps
    tx_stall_pct = 35;
    rx_gap_pct = 30;
    fork
      for (int i = 0; i < 40; i++)
        send_pkt(8'($urandom), 4'($urandom_range(15)), DW'($urandom));
      for (int i = 0; i < 40; i++) begin
        int kind;
        int ln;
        kind = int'($urandom_range(7));
        ln = int'($urandom_range(MAX_LEN));
        if (kind == 0)
          rx_pkt(8'($urandom), 8'($urandom_range(255, MAX_LEN + 1)), '0, -1, 1);
        else if (kind < 3)
          rx_pkt(8'($urandom), 8'(ln), DW'($urandom), int'($urandom_range(255)), 1);
        else
          rx_pkt(8'($urandom), 8'(ln), DW'($urandom), -1, 1);
      end
    join
    drain(3000);
    tx_stall_pct = 0;
    rx_gap_pct = 0;

    // Reset in the middle of a TX packet and an RX packet
    send_pkt(8'h5a, 4'd4, 32'h1122_3344);
    rx_fifo.push_back(8'h09);
    rx_fifo.push_back(8'h03);
    rx_fifo.push_back(8'haa);
    repeat (4) @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk("mid reset send_flag", send_flag, 1'b0);
    chk("mid reset recv_flag", recv_flag, 1'b0);
    chk("mid reset rx_valid", rx_valid, 1'b0);
    chk("mid reset tx_ready", tx_ready, 1'b1);
    tx_exp.delete();
    rx_exp.delete();
    rx_fifo.delete();
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    // Round trip through a loopback of the send stream into the receive FIFO
    loopback = 1;
    rx_pkt(8'hc3, 8'h03, 32'h0077_6655, -1, 0);
    send_pkt(8'hc3, 4'd3, 32'h9977_6655);
    drain(200);
    loopback = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_packet_ctrl.md
Name: uart_packet_ctrl

Overview:
- CPU-side packet engine that drives the byte-FIFO interface of the UART transceiver: it is the producer for the transceiver's send FIFO and the consumer for its receive FIFO.
- Serializes packets into the byte stream [channel, length, payload LSB-first, checksum].
- Parses the same format from received bytes and presents each complete packet to the CPU memory/IO controller as a one-cycle result.

Parameters:
- MAX_LEN, 4, maximum payload bytes per packet (1..8).
- TIMEOUT, 100000, CLK cycles allowed between received bytes inside a packet before abort.

Ports:
- CLK  in  1  clock
- RST_N  in  1  reset, asynchronous, active-low
- send_flag  out  1  push send_data into transceiver send FIFO
- send_data  out  8  byte to send
- sendable  in  1  send FIFO not full
- recv_flag  out  1  pop transceiver receive FIFO
- recv_data  in  8  receive FIFO head (first-word fall-through, valid while receivable)
- receivable  in  1  receive FIFO not empty
- tx_valid  in  1  packet request
- tx_ready  out  1  engine idle, request accepted when tx_valid & tx_ready
- tx_channel  in  8  channel byte
- tx_length  in  4  payload byte count
- tx_data  in  8*MAX_LEN  payload, byte 0 in bits [7:0]
- rx_valid  out  1  one-cycle pulse: packet finished (good or bad)
- rx_err  out  1  qualifies rx_valid: checksum, length or timeout error
- rx_channel  out  8  received channel
- rx_length  out  4  received payload count
- rx_data  out  8*MAX_LEN  received payload, unused upper bytes zero

Behaviour:
- Reset (RST_N low, asynchronous): all outputs 0 except tx_ready=1; both FSMs idle; checksum registers and timeout counter cleared. Reset mid-packet drops that packet silently, with no rx_valid.
- Checksum: XOR of channel, length and all payload bytes. The checksum byte is sent and checked as the last byte of each packet.
- TX FSM states: T_IDLE, T_CHAN, T_LEN, T_DATA, T_SUM.
  - tx_ready=1 only in T_IDLE.
  - On acceptance, latch channel, data and length. Lengths above MAX_LEN are clamped to MAX_LEN, and the clamped value is transmitted. Then go to T_CHAN.
  - In each non-idle state, one byte is emitted: send_flag=1 for exactly one cycle with send_data valid, only in a cycle where sendable=1. The state advances on the same edge.
  - While sendable=0, the FSM holds with send_flag=0.
  - Byte order: T_CHAN, then T_LEN, then T_DATA once per payload byte (byte index 0 upward), then T_SUM, then T_IDLE.
  - Length 0 skips T_DATA.
  - tx_ready rises the cycle after the checksum byte is pushed.
  - Minimum packet time is 3+N cycles.
- RX FSM states: R_IDLE, R_LEN, R_DATA, R_SUM, plus a one-cycle R_WAIT gap after every pop.
  - A byte is consumed when receivable=1 and the FSM is not in R_WAIT. recv_flag=1 for one cycle and recv_data is sampled in that same cycle. recv_flag therefore never asserts on two consecutive cycles.
  - R_IDLE: byte becomes channel, go to R_LEN.
  - R_LEN: if the value exceeds MAX_LEN, pulse rx_valid with rx_err=1 next cycle and return to R_IDLE (resync). If the value is 0, go to R_SUM. Otherwise go to R_DATA.
  - R_DATA: store each byte at the next byte index. After N bytes, go to R_SUM.
  - R_SUM: the next cycle pulses rx_valid with rx_err = (received checksum != computed checksum), then return to R_IDLE.
  - rx_channel, rx_length and rx_data are updated when rx_valid pulses and hold until the next pulse. rx_data bytes at index >= N are 0.
- Timeout:
  - The counter runs only outside R_IDLE and clears on each pop.
  - On reaching TIMEOUT-1, pulse rx_valid with rx_err=1 and return to R_IDLE. Partial fields are still updated.
- Consumer has no backpressure; rx_valid is never held.
- TX and RX are fully independent and may be active in the same cycle.

Test Plan:
- tx_channel=0x01, tx_length=2, tx_data=0x00003412, sendable=1 -> send_data sequence 01,02,12,34,25 on 5 consecutive cycles; tx_ready low for those 5 cycles.
- Same request with sendable held low for 3 cycles after the second byte -> send_flag=0 during the stall; byte sequence unchanged; no duplicates.
- Feed bytes 01,02,12,34,25 with receivable=1 -> recv_flag every other cycle; one rx_valid, rx_err=0, rx_channel=01, rx_length=2, rx_data=0x00003412.
- Feed 01,02,12,34,26 -> rx_valid with rx_err=1; then feed 07,00,07 -> rx_valid, rx_err=0, rx_length=0, rx_data=0.
- Feed 05,09 with MAX_LEN=4 -> rx_err pulse after the length byte, FSM back to R_IDLE. Separately, TIMEOUT=16, feed 01,02 then starve -> rx_err pulse 16 cycles after the last pop.
- Assert RST_N low mid-TX and mid-RX -> send_flag, recv_flag and rx_valid drop immediately, tx_ready=1; after release, a full packet round-trips correctly.
